// File: rtl/instruction_decoder_pkg.sv
// Shared encoding constants and decode helpers for the instruction decoder.
package instruction_decoder_pkg;

  typedef enum logic [2:0] {
    OP_LDI,
    OP_MOV,
    OP_ALU,
    OP_JMP,
    OP_JNZ
  } op_class_e;

  localparam logic [7:0] NOP_C8 = 8'hC8;
  localparam logic [7:0] NOP_CF = 8'hCF;
  localparam logic [7:0] NOP_D8 = 8'hD8;
  localparam logic [7:0] NOP_DF = 8'hDF;

  localparam logic [2:0] LOOP_DEST      = 3'b110;
  localparam logic [2:0] REG_ALU_RESULT = 3'd4;

  // Leading-ones prefix code: the first zero bit from the MSB selects the class.
  function automatic op_class_e op_class(input logic [7:0] ir);
    if (!ir[7])      return OP_LDI;
    else if (!ir[6]) return OP_MOV;
    else if (!ir[5]) return OP_ALU;
    else if (!ir[4]) return OP_JMP;
    else             return OP_JNZ;
  endfunction

  function automatic logic is_nop(input logic [7:0] ir);
    return (ir == NOP_C8) || (ir == NOP_CF) || (ir == NOP_D8) || (ir == NOP_DF);
  endfunction

endpackage

// File: rtl/instruction_decoder_if.sv
// Fetch/decode bundle between program memory/datapath (master) and the decoder (slave).
interface instruction_decoder_if #(
  parameter int CNT_W    = 8,
  parameter int NUM_REGS = 8
);
  logic [7:0]          pm_data;
  logic                alu_zero;
  logic [7:0]          ir;
  logic                jmp;
  logic                jmp_nz;
  logic [3:0]          jmp_addr;
  logic                dont_jmp;
  logic                NOPC8;
  logic                NOPCF;
  logic                NOPD8;
  logic                NOPDF;
  logic [NUM_REGS-1:0] reg_en;
  logic [2:0]          alu_func;
  logic                x_sel;
  logic                y_sel;
  logic [CNT_W-1:0]    counter;
  logic                count_en;

  modport master (
    output pm_data, alu_zero,
    input  ir, jmp, jmp_nz, jmp_addr, dont_jmp, NOPC8, NOPCF, NOPD8, NOPDF,
           reg_en, alu_func, x_sel, y_sel, counter, count_en
  );

  modport slave (
    input  pm_data, alu_zero,
    output ir, jmp, jmp_nz, jmp_addr, dont_jmp, NOPC8, NOPCF, NOPD8, NOPDF,
           reg_en, alu_func, x_sel, y_sel, counter, count_en
  );
endinterface

// File: rtl/instruction_decoder_loop_counter.sv
// Hardware loop counter: nibble load, decrement to zero, stop on zero or jump.
module instruction_decoder_loop_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [3:0]       load_nib_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] counter_o,
  output logic             count_en_o
);
  logic [CNT_W-1:0] counter_q, counter_d;
  logic             count_en_q, count_en_d;

  // NOTE: every always_comb output gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    counter_d  = counter_q;
    count_en_d = count_en_q;
    if (load_i) begin
      counter_d  = {load_nib_i, {(CNT_W-4){1'b0}}};
      count_en_d = 1'b1;
    end else if (clear_i) begin
      count_en_d = 1'b0;
    end else if (count_en_q) begin
      // Stop at zero rather than wrapping to all-ones.
      if (counter_q == '0) count_en_d = 1'b0;
      else                 counter_d  = counter_q - CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_q  <= '0;
      count_en_q <= 1'b0;
    end else begin
      counter_q  <= counter_d;
      count_en_q <= count_en_d;
    end
  end

  assign counter_o  = counter_q;
  assign count_en_o = count_en_q;
endmodule

// File: rtl/instruction_decoder.sv
// Instruction register, combinational decode, zero flag and loop counter control.
module instruction_decoder
  import instruction_decoder_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int NUM_REGS = 8
) (
  input logic            clk,
  input logic            reset,
  instruction_decoder_if.slave dec
);
  logic [7:0] ir_q;
  logic       dont_jmp_q, dont_jmp_d;
  op_class_e  cls;
  logic       nop;
  logic [NUM_REGS-1:0] reg_en;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [2:0] idx);
    return NUM_REGS'(1) << idx;
  endfunction

  always_comb begin
    cls = op_class(ir_q);
    nop = is_nop(ir_q);
  end

  // alu_zero belongs to the instruction currently in ir, so it is captured on the same edge ir advances.
  always_comb begin
    dont_jmp_d = dont_jmp_q;
    if (cls == OP_ALU && !nop) dont_jmp_d = dec.alu_zero;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q       <= 8'h00;
      dont_jmp_q <= 1'b0;
    end else begin
      ir_q       <= dec.pm_data;
      dont_jmp_q <= dont_jmp_d;
    end
  end

  always_comb begin
    reg_en = '0;
    unique case (cls)
      OP_LDI:  reg_en = onehot(ir_q[6:4]);
      OP_MOV:  reg_en = onehot(ir_q[5:3]);
      OP_ALU:  if (!nop) reg_en = onehot(REG_ALU_RESULT);
      default: reg_en = '0;
    endcase
  end

  assign dec.ir       = ir_q;
  assign dec.jmp      = (cls == OP_JMP);
  assign dec.jmp_nz   = (cls == OP_JNZ);
  assign dec.jmp_addr = ir_q[3:0];
  assign dec.dont_jmp = dont_jmp_q;
  assign dec.NOPC8    = (ir_q == NOP_C8);
  assign dec.NOPCF    = (ir_q == NOP_CF);
  assign dec.NOPD8    = (ir_q == NOP_D8);
  assign dec.NOPDF    = (ir_q == NOP_DF);
  assign dec.reg_en   = reg_en;
  assign dec.alu_func = ir_q[2:0];
  assign dec.x_sel    = ir_q[4];
  assign dec.y_sel    = ir_q[3];

  instruction_decoder_loop_counter #(.CNT_W(CNT_W)) u_loop_counter (
    .clk        (clk),
    .reset      (reset),
    .load_i     ((cls == OP_LDI) && (ir_q[6:4] == LOOP_DEST)),
    .load_nib_i (ir_q[3:0]),
    .clear_i    (cls == OP_JMP),
    .counter_o  (dec.counter),
    .count_en_o (dec.count_en)
  );
endmodule

// File: tb/tb_instruction_decoder.sv
// Directed bench for instruction_decoder: decode classes, zero flag, NOPs, loop counter, async reset.
module tb_instruction_decoder;
  logic clk;
  logic reset;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  instruction_decoder_if #(.CNT_W(8), .NUM_REGS(8)) dif ();

  instruction_decoder #(.CNT_W(8), .NUM_REGS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .dec   (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset        = 1'b1;
    dif.pm_data  = 8'h00;
    dif.alu_zero = 1'b0;
    @(negedge clk);
    check("rst_ir",       dif.ir,       8'h00);
    check("rst_dont_jmp", dif.dont_jmp, 1'b0);
    check("rst_counter",  dif.counter,  8'h00);
    check("rst_count_en", dif.count_en, 1'b0);
    check("rst_reg_en",   dif.reg_en,   8'h01);
    check("rst_jmp",      dif.jmp,      1'b0);
    check("rst_jmp_nz",   dif.jmp_nz,   1'b0);

    reset = 1'b0;
    dif.pm_data = 8'hE5;
    tick();
    check("e5_ir",       dif.ir,       8'hE5);
    check("e5_jmp",      dif.jmp,      1'b1);
    check("e5_jmp_addr", dif.jmp_addr, 4'h5);
    check("e5_jmp_nz",   dif.jmp_nz,   1'b0);
    check("e5_reg_en",   dif.reg_en,   8'h00);

    dif.pm_data = 8'hC1;
    tick();
    check("c1_reg_en",   dif.reg_en,   8'h10);
    check("c1_alu_func", dif.alu_func, 3'd1);
    check("c1_x_sel",    dif.x_sel,    1'b0);
    check("c1_dont_jmp", dif.dont_jmp, 1'b0);

    dif.alu_zero = 1'b1;
    dif.pm_data  = 8'hF3;
    tick();
    check("f3_dont_jmp", dif.dont_jmp, 1'b1);
    check("f3_jmp_nz",   dif.jmp_nz,   1'b1);
    check("f3_jmp",      dif.jmp,      1'b0);
    check("f3_jmp_addr", dif.jmp_addr, 4'h3);
    check("f3_reg_en",   dif.reg_en,   8'h00);

    // D0 is a real ALU op (x=1) and clears the flag; C8 then must not set it.
    dif.pm_data = 8'hD0;
    tick();
    check("d0_x_sel", dif.x_sel, 1'b1);
    dif.alu_zero = 1'b0;
    dif.pm_data  = 8'hC8;
    tick();
    check("c8_dont_jmp", dif.dont_jmp, 1'b0);
    check("c8_nop",      dif.NOPC8,    1'b1);
    check("c8_reg_en",   dif.reg_en,   8'h00);
    check("c8_y_sel",    dif.y_sel,    1'b1);
    dif.alu_zero = 1'b1;
    dif.pm_data  = 8'hDF;
    tick();
    check("df_dont_jmp", dif.dont_jmp, 1'b0);
    check("df_nopdf",    dif.NOPDF,    1'b1);
    check("df_nopc8",    dif.NOPC8,    1'b0);
    dif.alu_zero = 1'b0;
    dif.pm_data  = 8'hAB;
    tick();
    check("df_hold_flag", dif.dont_jmp, 1'b0);
    check("ab_mov_reg_en", dif.reg_en,  8'h20);

    dif.pm_data = 8'h35;
    tick();
    check("35_ldi_reg_en", dif.reg_en,  8'h08);
    check("35_count_en",   dif.count_en, 1'b0);

    // Loop counter full run: 0x20 down to 0, then stop.
    dif.pm_data = 8'h62;
    tick();
    check("62_reg_en", dif.reg_en, 8'h40);
    dif.pm_data = 8'h00;
    tick();
    check("ld20_counter",  dif.counter,  8'h20);
    check("ld20_count_en", dif.count_en, 1'b1);
    ticks(16);
    check("mid_counter", dif.counter, 8'h10);
    ticks(16);
    check("zero_counter",  dif.counter,  8'h00);
    check("zero_count_en", dif.count_en, 1'b1);
    tick();
    check("stop_count_en", dif.count_en, 1'b0);
    check("stop_counter",  dif.counter,  8'h00);
    tick();
    check("idle_counter", dif.counter, 8'h00);

    // Reload while counting, then jmp clears count_en.
    dif.pm_data = 8'h64;
    tick();
    dif.pm_data = 8'h00;
    tick();
    check("ld40_counter", dif.counter, 8'h40);
    tick();
    check("dec3f_counter", dif.counter, 8'h3F);
    dif.pm_data = 8'h61;
    tick();
    check("dec3e_counter", dif.counter, 8'h3E);
    dif.pm_data = 8'h00;
    tick();
    check("reload_counter",  dif.counter,  8'h10);
    check("reload_count_en", dif.count_en, 1'b1);
    tick();
    check("dec0f_counter", dif.counter, 8'h0F);
    dif.pm_data = 8'hE0;
    tick();
    check("dec0e_counter", dif.counter, 8'h0E);
    dif.pm_data = 8'h00;
    tick();
    check("jmp_count_en", dif.count_en, 1'b0);
    check("jmp_counter",  dif.counter,  8'h0E);
    tick();
    check("jmp_hold_counter", dif.counter, 8'h0E);

    // Build counter=0x37, dont_jmp=1, then assert reset between edges.
    dif.pm_data = 8'hC1;
    tick();
    dif.alu_zero = 1'b1;
    dif.pm_data  = 8'h64;
    tick();
    dif.alu_zero = 1'b0;
    dif.pm_data  = 8'h00;
    tick();
    ticks(9);
    check("pre_rst_counter",  dif.counter,  8'h37);
    check("pre_rst_dont_jmp", dif.dont_jmp, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("arst_ir",       dif.ir,       8'h00);
    check("arst_dont_jmp", dif.dont_jmp, 1'b0);
    check("arst_counter",  dif.counter,  8'h00);
    check("arst_count_en", dif.count_en, 1'b0);
    check("arst_reg_en",   dif.reg_en,   8'h01);
    @(negedge clk);
    reset = 1'b0;
    dif.pm_data = 8'hE9;
    tick();
    check("post_rst_jmp",      dif.jmp,      1'b1);
    check("post_rst_jmp_addr", dif.jmp_addr, 4'h9);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
